// File: rtl/mac_result_drain.sv
// mac_result_drain: pulls one 64-word result burst out of the accelerator,
// applies optional ReLU, arithmetic right-shift requantisation and signed
// 16-bit saturation, then packs result pairs into 32-bit activation writes.
// A stalled stream is caught by a consecutive-idle-cycle timeout.

module mac_result_drain #(
   parameter int BATCH   = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        relu_en,
   input  logic [4:0]                  shift_amt,
   output logic                        EN_readMem,
   input  logic                        VALID_memVal,
   input  logic [31:0]                 memVal_data,
   output logic                        act_wr_en,
   output logic [$clog2(BATCH/2)-1:0]  act_wr_addr,
   output logic [31:0]                 act_wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [$clog2(BATCH):0]      sat_cnt
);

   localparam int AW = $clog2(BATCH / 2);
   localparam int IW = $clog2(BATCH);
   localparam int CW = IW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      STREAM,
      DONE,
      ERR
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   idx_q;
   logic [TW-1:0]   timer_q;
   logic            relu_q;
   logic [4:0]      shift_q;
   logic [15:0]     lowHalf_q;
   logic            enReadMem_q;
   logic            actWrEn_q;
   logic [AW-1:0]   actWrAddr_q;
   logic [31:0]     actWrData_q;
   logic            busy_q;
   logic            done_q;
   logic            error_q;
   logic [CW-1:0]   satCnt_q;

   logic signed [31:0] xVal;
   logic signed [31:0] yVal;
   logic [15:0]        procWord_d;
   logic               procSat_d;

   // Per-word datapath: ReLU, arithmetic shift, then clamp into signed 16 bits
   always_comb begin
      xVal       = signed'(memVal_data);
      yVal       = '0;
      procWord_d = '0;
      procSat_d  = 1'b0;
      if (relu_q && (xVal < 0)) begin
         xVal = '0;
      end
      yVal = xVal >>> shift_q;
      if (yVal > 32'sd32767) begin
         procWord_d = 16'h7FFF;
         procSat_d  = 1'b1;
      end else if (yVal < -32'sd32768) begin
         procWord_d = 16'h8000;
         procSat_d  = 1'b1;
      end else begin
         procWord_d = yVal[15:0];
      end
   end

   // Drain sequencer: request, collect the burst, pack pairs, watch for stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         timer_q     <= '0;
         relu_q      <= 1'b0;
         shift_q     <= '0;
         lowHalf_q   <= '0;
         enReadMem_q <= 1'b0;
         actWrEn_q   <= 1'b0;
         actWrAddr_q <= '0;
         actWrData_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         satCnt_q    <= '0;
      end else begin
         enReadMem_q <= 1'b0;
         actWrEn_q   <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE, ERR: begin
               if (start) begin
                  state_q     <= REQ;
                  error_q     <= 1'b0;
                  satCnt_q    <= '0;
                  idx_q       <= '0;
                  timer_q     <= '0;
                  relu_q      <= relu_en;
                  shift_q     <= shift_amt;
                  enReadMem_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            REQ: begin
               state_q <= WAIT;
               timer_q <= '0;
            end
            WAIT, STREAM: begin
               if (VALID_memVal) begin
                  timer_q <= '0;
                  if (procSat_d) begin
                     satCnt_q <= satCnt_q + CW'(1);
                  end
                  if (!idx_q[0]) begin
                     lowHalf_q <= procWord_d;
                  end else begin
                     actWrEn_q   <= 1'b1;
                     actWrAddr_q <= AW'(idx_q >> 1);
                     actWrData_q <= {procWord_d, lowHalf_q};
                  end
                  if (idx_q == IW'(BATCH - 1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= STREAM;
                     idx_q   <= idx_q + IW'(1);
                  end
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign EN_readMem  = enReadMem_q;
   assign act_wr_en   = actWrEn_q;
   assign act_wr_addr = actWrAddr_q;
   assign act_wr_data = actWrData_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign sat_cnt     = satCnt_q;

endmodule
